// File: rtl/ec_plot_renderer.sv
// Pixel-colour stage for the elliptic-curve plot: latches curve points into a
// 64x64 cell bitmap and colours each VGA pixel through a two-stage pipeline.
module ec_plot_renderer #(
    parameter logic [9:0] ORIGIN_X = 10'd192,
    parameter logic [9:0] ORIGIN_Y = 10'd112
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        VGA_BLANK_N,
    input  logic        pt_valid,
    input  logic [7:0]  pt_x,
    input  logic [7:0]  pt_y,
    output logic        pt_ready,
    input  logic        clear_req,
    output logic        busy,
    output logic [12:0] point_count,
    output logic        dropped,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t      state_q, state_d;
    logic [5:0]  clr_row_q, clr_row_d;
    logic [12:0] point_count_q, point_count_d;
    logic        dropped_q, dropped_d;
    logic        last_valid_q, last_valid_d;
    logic [5:0]  last_x_q, last_x_d;
    logic [5:0]  last_y_q, last_y_d;
    logic [63:0] bitmap_q [64];
    logic [63:0] bitmap_d [64];

    logic        in_area_q, in_area_d;
    logic        on_border_q, on_border_d;
    logic        blank_n_q;
    logic [5:0]  col_q, col_d;
    logic [5:0]  row_q, row_d;
    logic [23:0] rgb_q, rgb_d;

    logic        in_range;
    logic [10:0] x_ext, y_ext, ox_ext, oy_ext;
    logic        in_x, in_y, ring_x, ring_y;
    logic        pix_on, is_last;

    assign in_range = (pt_x[7:6] == 2'b00) && (pt_y[7:6] == 2'b00);

    // Control and bitmap update; a clear request always wins over a point write.
    always_comb begin
        state_d       = state_q;
        clr_row_d     = clr_row_q;
        point_count_d = point_count_q;
        dropped_d     = dropped_q;
        last_valid_d  = last_valid_q;
        last_x_d      = last_x_q;
        last_y_d      = last_y_q;
        bitmap_d      = bitmap_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d       = CLEAR;
                    clr_row_d     = 6'd0;
                    point_count_d = 13'd0;
                    dropped_d     = 1'b0;
                    last_valid_d  = 1'b0;
                end else if (pt_valid) begin
                    if (in_range) begin
                        bitmap_d[~pt_y[5:0]][pt_x[5:0]] = 1'b1;
                        last_x_d     = pt_x[5:0];
                        last_y_d     = pt_y[5:0];
                        last_valid_d = 1'b1;
                        if (point_count_q != 13'h1FFF)
                            point_count_d = point_count_q + 13'd1;
                    end else begin
                        dropped_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                bitmap_d[clr_row_q] = '0;
                if (clear_req)
                    clr_row_d = 6'd0;
                else if (clr_row_q == 6'd63)
                    state_d = IDLE;
                else
                    clr_row_d = clr_row_q + 6'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // S1: plot-area geometry, computed 11 bits wide so the ring never wraps.
    always_comb begin
        x_ext  = {1'b0, DrawX};
        y_ext  = {1'b0, DrawY};
        ox_ext = {1'b0, ORIGIN_X};
        oy_ext = {1'b0, ORIGIN_Y};
        in_x   = (x_ext >= ox_ext) && (x_ext < ox_ext + 11'd256);
        in_y   = (y_ext >= oy_ext) && (y_ext < oy_ext + 11'd256);
        ring_x = (x_ext + 11'd1 >= ox_ext) && (x_ext <= ox_ext + 11'd256);
        ring_y = (y_ext + 11'd1 >= oy_ext) && (y_ext <= oy_ext + 11'd256);
        in_area_d   = in_x && in_y;
        on_border_d = ring_x && ring_y && !(in_x && in_y);
        col_d = 6'((DrawX - ORIGIN_X) >> 2);
        row_d = 6'((DrawY - ORIGIN_Y) >> 2);
    end

    // S2: colour priority; bitmap row index is already flipped (row 63 - y).
    always_comb begin
        pix_on  = bitmap_q[row_q][col_q];
        is_last = last_valid_q && (col_q == last_x_q) && (row_q == ~last_y_q);
        rgb_d   = 24'h000000;
        if (!blank_n_q)
            rgb_d = 24'h000000;
        else if (in_area_q && is_last)
            rgb_d = 24'hFF0000;
        else if (in_area_q && pix_on)
            rgb_d = 24'hFFFFFF;
        else if (on_border_q)
            rgb_d = 24'h404040;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= IDLE;
            clr_row_q     <= 6'd0;
            point_count_q <= 13'd0;
            dropped_q     <= 1'b0;
            last_valid_q  <= 1'b0;
            last_x_q      <= 6'd0;
            last_y_q      <= 6'd0;
            for (int i = 0; i < 64; i++)
                bitmap_q[i] <= '0;
            in_area_q     <= 1'b0;
            on_border_q   <= 1'b0;
            blank_n_q     <= 1'b0;
            col_q         <= 6'd0;
            row_q         <= 6'd0;
            rgb_q         <= 24'h000000;
        end else begin
            state_q       <= state_d;
            clr_row_q     <= clr_row_d;
            point_count_q <= point_count_d;
            dropped_q     <= dropped_d;
            last_valid_q  <= last_valid_d;
            last_x_q      <= last_x_d;
            last_y_q      <= last_y_d;
            for (int i = 0; i < 64; i++)
                bitmap_q[i] <= bitmap_d[i];
            in_area_q     <= in_area_d;
            on_border_q   <= on_border_d;
            blank_n_q     <= VGA_BLANK_N;
            col_q         <= col_d;
            row_q         <= row_d;
            rgb_q         <= rgb_d;
        end
    end

    assign pt_ready    = (state_q == IDLE);
    assign busy        = (state_q == CLEAR);
    assign point_count = point_count_q;
    assign dropped     = dropped_q;
    assign VGA_R       = rgb_q[23:16];
    assign VGA_G       = rgb_q[15:8];
    assign VGA_B       = rgb_q[7:0];

endmodule

// File: tb/tb_ec_plot_renderer.sv
// Directed self-checking bench for ec_plot_renderer: plotting, scanout colours,
// out-of-range drops, clear timing, collision, saturation and blanking.
module tb_ec_plot_renderer;

    localparam logic [9:0] OX = 10'd192;
    localparam logic [9:0] OY = 10'd112;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  draw_x = 10'd0;
    logic [9:0]  draw_y = 10'd0;
    logic        blank_n = 1'b1;
    logic        pt_valid = 1'b0;
    logic [7:0]  pt_x = 8'd0;
    logic [7:0]  pt_y = 8'd0;
    logic        pt_ready;
    logic        clear_req = 1'b0;
    logic        busy;
    logic [12:0] point_count;
    logic        dropped;
    logic [7:0]  vga_r, vga_g, vga_b;

    int checks = 0;
    int failures = 0;

    ec_plot_renderer #(.ORIGIN_X(OX), .ORIGIN_Y(OY)) dut (
        .Clk(clk), .Reset(rst),
        .DrawX(draw_x), .DrawY(draw_y), .VGA_BLANK_N(blank_n),
        .pt_valid(pt_valid), .pt_x(pt_x), .pt_y(pt_y), .pt_ready(pt_ready),
        .clear_req(clear_req), .busy(busy),
        .point_count(point_count), .dropped(dropped),
        .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b)
    );

    always #20 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic plot(input logic [7:0] x, input logic [7:0] y);
        pt_valid = 1'b1;
        pt_x = x;
        pt_y = y;
        step();
        pt_valid = 1'b0;
    endtask

    task automatic scan(input string tag, input logic [9:0] x, input logic [9:0] y,
                        input logic bn, input logic [23:0] exp);
        draw_x = x;
        draw_y = y;
        blank_n = bn;
        step();
        step();
        check_eq(tag, {8'h0, vga_r, vga_g, vga_b}, {8'h0, exp});
        blank_n = 1'b1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 300) begin
            step();
            n++;
        end
    endtask

    int n;

    initial begin
        step();
        step();
        rst = 1'b0;
        step();
        check_eq("rst_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
        check_eq("rst_ready", pt_ready, 1);
        check_eq("rst_count", point_count, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_dropped", dropped, 0);

        // Plot and scan out
        plot(8'd5, 8'd0);
        plot(8'd5, 8'd63);
        scan("cell_5_0_white", OX + 10'd20, OY + 10'd252, 1'b1, 24'hFFFFFF);
        scan("cell_5_63_red", OX + 10'd20, OY + 10'd0, 1'b1, 24'hFF0000);
        scan("border_left", OX - 10'd1, OY, 1'b1, 24'h404040);
        scan("border_corner", OX + 10'd256, OY + 10'd256, 1'b1, 24'h404040);
        scan("unlit_cell", OX + 10'd24, OY + 10'd252, 1'b1, 24'h000000);
        scan("outside", 10'd10, 10'd10, 1'b1, 24'h000000);
        scan("blank_lit", OX + 10'd20, OY + 10'd252, 1'b0, 24'h000000);
        check_eq("count_2", point_count, 2);

        // Out-of-range points
        check_eq("oor_ready", pt_ready, 1);
        plot(8'd64, 8'd3);
        plot(8'd200, 8'd200);
        check_eq("oor_dropped", dropped, 1);
        check_eq("oor_count", point_count, 2);
        scan("oor_alias_64_3", OX + 10'd0, OY + 10'd240, 1'b1, 24'h000000);
        scan("oor_alias_200", OX + 10'd32, OY + 10'd220, 1'b1, 24'h000000);

        // Clear after ten points
        for (int i = 10; i < 20; i++)
            plot(8'(i), 8'(i));
        check_eq("count_12", point_count, 12);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        check_eq("clr_busy", busy, 1);
        check_eq("clr_ready_low", pt_ready, 0);
        wait_idle(n);
        check_eq("clr_cycles", n, 64);
        check_eq("clr_ready_back", pt_ready, 1);
        check_eq("clr_count", point_count, 0);
        check_eq("clr_dropped", dropped, 0);
        scan("clr_cell_19", OX + 10'd76, OY + 10'd176, 1'b1, 24'h000000);
        scan("clr_cell_5_0", OX + 10'd20, OY + 10'd252, 1'b1, 24'h000000);

        // Clear restarted at cycle 30
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        n = 0;
        while (busy && n < 300) begin
            clear_req = (n == 29);
            step();
            n++;
        end
        clear_req = 1'b0;
        check_eq("clr_extended", n, 94);

        // Collision of clear and point
        pt_valid = 1'b1;
        pt_x = 8'd1;
        pt_y = 8'd1;
        clear_req = 1'b1;
        step();
        pt_valid = 1'b0;
        clear_req = 1'b0;
        wait_idle(n);
        check_eq("coll_cycles", n, 64);
        check_eq("coll_count", point_count, 0);
        scan("coll_cell_dark", OX + 10'd4, OY + 10'd248, 1'b1, 24'h000000);

        // Saturation
        pt_valid = 1'b1;
        pt_x = 8'd2;
        pt_y = 8'd2;
        for (int i = 0; i < 8200; i++)
            step();
        pt_valid = 1'b0;
        check_eq("sat_count", point_count, 8191);
        scan("sat_last_red", OX + 10'd8, OY + 10'd244, 1'b1, 24'hFF0000);

        // Reset mid-clear
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        step();
        step();
        rst = 1'b1;
        #5;
        check_eq("rstclr_busy", busy, 0);
        check_eq("rstclr_ready", pt_ready, 1);
        step();
        rst = 1'b0;
        check_eq("rstclr_count", point_count, 0);
        scan("rstclr_cell_dark", OX + 10'd8, OY + 10'd244, 1'b1, 24'h000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ec_plot_renderer.md
# ec_plot_renderer

Pixel-colour stage for the elliptic-curve display. It accepts affine curve points (x, y) from the point-arithmetic engine over a valid/ready handshake and latches them into a 64×64 one-bit cell bitmap. It then colours each pixel addressed by the VGA timing generator's DrawX/DrawY/VGA_BLANK_N outputs, and drives VGA_R/G/B to the video DAC. The block sits directly downstream of the VGA timing generator and shares its 25 MHz pixel clock.

## Interface
Parameters:
- ORIGIN_X, 10'd192: left pixel column of the 256×256 plot area.
- ORIGIN_Y, 10'd112: top pixel row of the plot area.

Ports:
- Clk  in  1  25 MHz pixel clock; the only clock.
- Reset  in  1  asynchronous, active-high reset.
- DrawX  in  10  current pixel column from the timing generator.
- DrawY  in  10  current pixel row from the timing generator.
- VGA_BLANK_N  in  1  active-low blanking from the timing generator.
- pt_valid  in  1  point offered.
- pt_x  in  8  point x coordinate.
- pt_y  in  8  point y coordinate.
- pt_ready  out  1  point accepted when pt_valid && pt_ready.
- clear_req  in  1  single-cycle request to erase the bitmap.
- busy  out  1  high while clearing.
- point_count  out  13  accepted in-range points, saturating.
- dropped  out  1  sticky flag: an out-of-range point was accepted.
- VGA_R, VGA_G, VGA_B  out  8 each  pixel colour.

## Operation
- Storage:
  - bitmap[63:0][63:0] in flops.
  - Cell (x, y) is stored at row 63−y, column x, so y = 0 is drawn at the bottom.
- Control FSM states: IDLE, CLEAR.
  - pt_ready = (state == IDLE).
  - IDLE → CLEAR on clear_req. This transition sets clr_row = 0, point_count = 0, dropped = 0 and last_valid = 0.
  - CLEAR zeroes bitmap row clr_row each cycle and increments clr_row. After row 63 is cleared it returns to IDLE, so CLEAR lasts exactly 64 cycles.
  - clear_req while in CLEAR restarts clr_row at 0.
  - busy = (state == CLEAR).
- Point accept (IDLE, pt_valid high):
  - If pt_x < 64 and pt_y < 64: set the bitmap bit, register last_x/last_y, set last_valid, and increment point_count, saturating at 8191. Duplicate points still count.
  - Otherwise the handshake still completes, the bitmap is untouched and dropped is set.
- Same-cycle clear_req and pt_valid in IDLE: the point handshake completes, its write is discarded, and the clear proceeds as above. The count ends at 0.
- Scanout pipeline:
  - S1 registers DrawX, DrawY and VGA_BLANK_N, and computes:
    - in_area: DrawX ∈ [ORIGIN_X, ORIGIN_X+256) and DrawY ∈ [ORIGIN_Y, ORIGIN_Y+256).
    - on_border: the one-pixel ring just outside the plot area.
    - cell column = (DrawX−ORIGIN_X)>>2, cell row = (DrawY−ORIGIN_Y)>>2, using 10-bit subtract then the low 6 bits.
  - S2 reads the bitmap bit and registers the colour. Priority is:
    1. Blank (S1 blank_n low): 000000.
    2. in_area, last_valid set and cell equals the last point: FF0000.
    3. in_area with the bitmap bit set: FFFFFF.
    4. on_border: 404040.
    5. Otherwise: 000000.
- Scanout reads observe bitmap writes from the previous cycle. Clears mid-frame are visible immediately, and tearing is accepted.

## Timing
- Reset (asynchronous):
  - state = IDLE, pt_ready = 1.
  - bitmap all 0, point_count = 0, dropped = 0, last_valid = 0.
  - Pipeline registers 0, so VGA_R/G/B = 0.
- Colour latency: VGA_R/G/B reflect the DrawX/DrawY/VGA_BLANK_N sampled 2 Clk edges earlier. The top level must delay VGA_HS/VGA_VS by 2 cycles to keep alignment.
- Point write: the bitmap bit and count update on the accepting edge, and the pixel becomes visible 2 cycles after that.
- Clear:
  - The clear_req edge enters CLEAR.
  - pt_ready is low for exactly 64 cycles and returns high on the 65th edge.
- Reset asserted mid-clear aborts the clear. Since reset zeroes the bitmap, the result is an empty bitmap.

## Test plan
- Reset release: VGA_R/G/B = 0, pt_ready = 1, point_count = 0, busy = 0.
- Plot and scan out:
  - Plot (5, 0) and (5, 63).
  - Scan pixel (ORIGIN_X+20, ORIGIN_Y+252): it shows FFFFFF 2 cycles later.
  - Pixel (ORIGIN_X+20, ORIGIN_Y+0) shows FF0000, because (5, 63) is the last point.
  - (ORIGIN_X−1, ORIGIN_Y) shows 404040.
  - point_count = 2.
- Out-of-range: offer (64, 3), then (200, 200).
  - Both handshakes complete, dropped = 1, point_count is unchanged and no cell is lit.
- Clear:
  - Plot 10 points, then pulse clear_req.
  - busy and !pt_ready hold for 64 cycles, after which the bitmap is all 0 and point_count = 0.
  - A clear_req at cycle 30 of the clear extends the clear to 94 cycles total.
- Collision and saturation:
  - clear_req in the same cycle as an accepted (1, 1): the cell stays dark and count = 0.
  - 8200 accepted points: point_count = 8191.
- Blank: drive VGA_BLANK_N = 0 over a lit cell; the output is 000000.
